// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and types for the 2-way SRAM read cache
package cache_pkg;

  localparam int SETS      = 64;
  localparam int INDEX_W   = $clog2(SETS);
  localparam int TAG_W     = 10;
  localparam int WORD_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } line_t;

endpackage

// File: rtl/cache_set_array.sv
// rtl/cache_set_array.sv - 2-way tag/data/valid storage with per-set lru bit
module cache_set_array
  import cache_pkg::*;
#(
  parameter int SETS_P  = SETS,
  parameter int TAG_WP  = TAG_W,
  parameter int INDEX_WP = $clog2(SETS_P)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_WP-1:0] index,
  input  logic [TAG_WP-1:0]   tag,
  output logic                hit,
  output logic                hit_way,
  output logic                victim_way,
  output logic [63:0]         hit_line,
  input  logic                fill_en,
  input  logic                fill_way,
  input  logic [63:0]         fill_data,
  input  logic                inval_en,
  input  logic                inval_way,
  input  logic                lru_en,
  input  logic                lru_val
);

  logic [1:0]        valid [SETS_P];
  logic              lru   [SETS_P];
  logic [TAG_WP-1:0] tag0  [SETS_P];
  logic [TAG_WP-1:0] tag1  [SETS_P];
  logic [63:0]       data0 [SETS_P];
  logic [63:0]       data1 [SETS_P];

  logic hit0, hit1;

  always_comb begin
    hit0       = valid[index][0] && (tag0[index] == tag);
    hit1       = valid[index][1] && (tag1[index] == tag);
    hit        = hit0 | hit1;
    hit_way    = ~hit0 & hit1;
    hit_line   = hit_way ? data1[index] : data0[index];
    // Fill an empty way before evicting anything, way 0 first.
    if (!valid[index][0])      victim_way = 1'b0;
    else if (!valid[index][1]) victim_way = 1'b1;
    else                       victim_way = lru[index];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS_P; s++) begin
        valid[s] <= 2'b00;
        lru[s]   <= 1'b0;
      end
    end else begin
      if (fill_en)  valid[index][fill_way]  <= 1'b1;
      if (inval_en) valid[index][inval_way] <= 1'b0;
      if (lru_en)   lru[index]              <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (fill_way) begin
        tag1[index]  <= tag;
        data1[index] <= fill_data;
      end else begin
        tag0[index]  <= tag;
        data0[index] <= fill_data;
      end
    end
  end

endmodule

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - 2-way read cache between MEM stage and SRAM controller
module sram_cache_controller
  import cache_pkg::*;
#(
  parameter int SETS_P = SETS,
  parameter int TAG_WP = TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_R_EN,
  output logic        sram_W_EN,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int INDEX_WP = $clog2(SETS_P);

  state_t state, next_state;

  logic [INDEX_WP-1:0] index;
  logic [TAG_WP-1:0]   tag;
  logic                hit, hit_way, victim_way;
  logic [63:0]         hit_line;
  logic                fill_en, inval_en, inval_way, lru_en, lru_val;

  assign index        = address[INDEX_LSB +: INDEX_WP];
  assign tag          = address[INDEX_LSB + INDEX_WP +: TAG_WP];
  assign sram_address = address;
  assign sram_wdata   = wdata;

  cache_set_array #(
    .SETS_P  (SETS_P),
    .TAG_WP  (TAG_WP),
    .INDEX_WP(INDEX_WP)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .tag       (tag),
    .hit       (hit),
    .hit_way   (hit_way),
    .victim_way(victim_way),
    .hit_line  (hit_line),
    .fill_en   (fill_en),
    .fill_way  (victim_way),
    .fill_data (sram_rdata),
    .inval_en  (inval_en),
    .inval_way (inval_way),
    .lru_en    (lru_en),
    .lru_val   (lru_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b1;
    rdata      = 32'h0;
    sram_R_EN  = 1'b0;
    sram_W_EN  = 1'b0;
    fill_en    = 1'b0;
    inval_en   = 1'b0;
    inval_way  = hit_way;
    lru_en     = 1'b0;
    lru_val    = 1'b0;
    // Outputs read as idle while reset is held, even with a request pending.
    if (rst) begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            ready      = 1'b0;
            sram_W_EN  = 1'b1;
            next_state = WRITE;
          end else if (MEM_R_EN) begin
            if (hit) begin
              rdata   = address[WORD_BIT] ? hit_line[63:32] : hit_line[31:0];
              lru_en  = 1'b1;
              lru_val = ~hit_way;
            end else begin
              ready      = 1'b0;
              sram_R_EN  = 1'b1;
              next_state = READ_MISS;
            end
          end
        end
        READ_MISS: begin
          sram_R_EN = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            ready      = 1'b1;
            rdata      = address[WORD_BIT] ? sram_rdata[63:32] : sram_rdata[31:0];
            fill_en    = 1'b1;
            lru_en     = 1'b1;
            lru_val    = ~victim_way;
            next_state = IDLE;
          end
        end
        WRITE: begin
          sram_W_EN = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            ready      = 1'b1;
            inval_en   = hit;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cache_controller.sv
// tb/tb_sram_cache_controller.sv - directed self-checking bench for sram_cache_controller
module tb_sram_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, sram_R_EN, sram_W_EN;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_R_EN   (sram_R_EN),
    .sram_W_EN   (sram_W_EN),
    .sram_address(sram_address),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_ready  (sram_ready)
  );

  // Stimulus drivers: called at posedge+1, return at posedge+1 with enables low.
  task automatic miss_txn(input logic [31:0] addr, input logic [63:0] line, input int lat,
                          output int stall, output logic en_ok, output logic rdy_done,
                          output logic [31:0] rd_done);
    address = addr; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; stall = 0; en_ok = 1'b1;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (ready === 1'b0) stall++;
      if (sram_R_EN !== 1'b1 || sram_W_EN !== 1'b0) en_ok = 1'b0;
      @(posedge clk); #1;
    end
    sram_ready = 1'b1; sram_rdata = line;
    @(negedge clk);
    rdy_done = ready; rd_done = rdata;
    if (sram_R_EN !== 1'b1) en_ok = 1'b0;
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic hit_txn(input logic [31:0] addr, output logic rdy, output logic [31:0] rd,
                         output logic ren);
    address = addr; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
    @(negedge clk);
    rdy = ready; rd = rdata; ren = sram_R_EN | sram_W_EN;
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic both,
                           input int lat, output int stall, output logic w_ok,
                           output logic r_seen, output logic rdy_done, output logic pass_ok);
    address = addr; wdata = data; MEM_W_EN = 1'b1; MEM_R_EN = both;
    stall = 0; w_ok = 1'b1; r_seen = 1'b0; pass_ok = 1'b1;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (ready === 1'b0) stall++;
      if (sram_W_EN !== 1'b1) w_ok = 1'b0;
      if (sram_R_EN !== 1'b0) r_seen = 1'b1;
      if (sram_address !== addr || sram_wdata !== data) pass_ok = 1'b0;
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    @(negedge clk);
    rdy_done = ready;
    if (sram_W_EN !== 1'b1) w_ok = 1'b0;
    if (sram_R_EN !== 1'b0) r_seen = 1'b1;
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'h10; wdata = 32'h0;
    sram_rdata = 64'h0; sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (sram_R_EN !== 1'b0) begin errors++; $display("FAIL reset_sram_R_EN got=%b exp=0", sram_R_EN); end
    checks++; if (sram_W_EN !== 1'b0) begin errors++; $display("FAIL reset_sram_W_EN got=%b exp=0", sram_W_EN); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_and_hit();
    int stall; logic en_ok, rdy, ren; logic [31:0] rd;
    miss_txn(32'h10, 64'hBBBB_BBBB_AAAA_AAAA, 3, stall, en_ok, rdy, rd);
    checks++; if (stall !== 3) begin errors++; $display("FAIL miss_stall got=%0d exp=3", stall); end
    checks++; if (en_ok !== 1'b1) begin errors++; $display("FAIL miss_sram_R_EN got=%b exp=1", en_ok); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL miss_done_ready got=%b exp=1", rdy); end
    checks++; if (rd !== 32'hAAAA_AAAA) begin errors++; $display("FAIL miss_rdata got=%h exp=aaaaaaaa", rd); end
    hit_txn(32'h14, rdy, rd, ren);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL hit_ready got=%b exp=1", rdy); end
    checks++; if (rd !== 32'hBBBB_BBBB) begin errors++; $display("FAIL hit_rdata got=%h exp=bbbbbbbb", rd); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL hit_sram_en got=%b exp=0", ren); end
  endtask

  task automatic test_eviction();
    int stall; logic en_ok, rdy, ren; logic [31:0] rd;
    miss_txn(32'h210, 64'h1111_0001_1111_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || rd !== 32'h1111_0000) begin errors++; $display("FAIL fill_210 stall=%0d rdata=%h exp 1 11110000", stall, rd); end
    miss_txn(32'h410, 64'h2222_0001_2222_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || rd !== 32'h2222_0000) begin errors++; $display("FAIL fill_410 stall=%0d rdata=%h exp 1 22220000", stall, rd); end
    hit_txn(32'h210, rdy, rd, ren);
    checks++; if (rdy !== 1'b1 || rd !== 32'h1111_0000 || ren !== 1'b0) begin errors++; $display("FAIL evict_hit_210 ready=%b rdata=%h en=%b exp 1 11110000 0", rdy, rd, ren); end
    miss_txn(32'h10, 64'h3333_0001_3333_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || en_ok !== 1'b1) begin errors++; $display("FAIL evicted_010_miss stall=%0d en=%b exp 1 1", stall, en_ok); end
    checks++; if (rd !== 32'h3333_0000) begin errors++; $display("FAIL refill_010_rdata got=%h exp=33330000", rd); end
    hit_txn(32'h14, rdy, rd, ren);
    checks++; if (rdy !== 1'b1 || rd !== 32'h3333_0001) begin errors++; $display("FAIL refill_014_hit ready=%b rdata=%h exp 1 33330001", rdy, rd); end
  endtask

  task automatic test_write_invalidate();
    int stall; logic w_ok, r_seen, rdy, pass_ok, en_ok, ren; logic [31:0] rd;
    hit_txn(32'h210, rdy, rd, ren);
    checks++; if (rdy !== 1'b1 || rd !== 32'h1111_0000) begin errors++; $display("FAIL pre_write_hit ready=%b rdata=%h exp 1 11110000", rdy, rd); end
    write_txn(32'h210, 32'h1234_5678, 1'b0, 2, stall, w_ok, r_seen, rdy, pass_ok);
    checks++; if (stall !== 2 || rdy !== 1'b1) begin errors++; $display("FAIL write_stall stall=%0d ready=%b exp 2 1", stall, rdy); end
    checks++; if (w_ok !== 1'b1 || r_seen !== 1'b0) begin errors++; $display("FAIL write_enables w_ok=%b r_seen=%b exp 1 0", w_ok, r_seen); end
    checks++; if (pass_ok !== 1'b1) begin errors++; $display("FAIL write_passthrough got=%b exp=1", pass_ok); end
    hit_txn(32'h10, rdy, rd, ren);
    checks++; if (rdy !== 1'b1 || rd !== 32'h3333_0000) begin errors++; $display("FAIL other_way_kept ready=%b rdata=%h exp 1 33330000", rdy, rd); end
    miss_txn(32'h210, 64'h4444_0001_4444_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || en_ok !== 1'b1 || rd !== 32'h4444_0000) begin errors++; $display("FAIL invalidated_miss stall=%0d en=%b rdata=%h exp 1 1 44440000", stall, en_ok, rd); end
  endtask

  task automatic test_rw_priority();
    int stall; logic w_ok, r_seen, rdy, pass_ok, en_ok; logic [31:0] rd;
    write_txn(32'h20, 32'hCAFE_F00D, 1'b1, 1, stall, w_ok, r_seen, rdy, pass_ok);
    checks++; if (w_ok !== 1'b1 || r_seen !== 1'b0 || stall !== 1) begin errors++; $display("FAIL rw_priority w_ok=%b r_seen=%b stall=%0d exp 1 0 1", w_ok, r_seen, stall); end
    miss_txn(32'h20, 64'h5555_0001_5555_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || en_ok !== 1'b1) begin errors++; $display("FAIL rw_no_fill stall=%0d en=%b exp 1 1", stall, en_ok); end
  endtask

  task automatic test_idle_sram_ready();
    int stall; logic en_ok, rdy; logic [31:0] rd;
    address = 32'h60; sram_rdata = 64'h6666_0001_6666_0000; sram_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL idle_sram_ready ready=%b rdata=%h exp 1 0", ready, rdata); end
    @(posedge clk); #1;
    sram_ready = 1'b0;
    miss_txn(32'h60, 64'h6666_0001_6666_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1) begin errors++; $display("FAIL idle_ready_no_fill stall=%0d exp=1", stall); end
  endtask

  task automatic test_reset_mid_miss();
    int stall; logic en_ok, rdy, ren; logic [31:0] rd;
    address = 32'h40; MEM_R_EN = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || sram_R_EN !== 1'b0) begin errors++; $display("FAIL reset_abort ready=%b sram_R_EN=%b exp 1 0", ready, sram_R_EN); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || sram_R_EN !== 1'b1) begin errors++; $display("FAIL reset_rerequest ready=%b sram_R_EN=%b exp 0 1", ready, sram_R_EN); end
    @(posedge clk); #1;
    sram_ready = 1'b1; sram_rdata = 64'h7777_0001_7777_0000;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== 32'h7777_0000) begin errors++; $display("FAIL reset_refill ready=%b rdata=%h exp 1 77770000", ready, rdata); end
    @(posedge clk); #1;
    sram_ready = 1'b0; MEM_R_EN = 1'b0;
    hit_txn(32'h44, rdy, rd, ren);
    checks++; if (rdy !== 1'b1 || rd !== 32'h7777_0001 || ren !== 1'b0) begin errors++; $display("FAIL reset_then_hit ready=%b rdata=%h en=%b exp 1 77770001 0", rdy, rd, ren); end
    miss_txn(32'h10, 64'h8888_0001_8888_0000, 1, stall, en_ok, rdy, rd);
    checks++; if (stall !== 1 || en_ok !== 1'b1) begin errors++; $display("FAIL reset_cleared_cache stall=%0d en=%b exp 1 1", stall, en_ok); end
  endtask

  initial begin
    test_reset();
    test_read_miss_and_hit();
    test_eviction();
    test_write_invalidate();
    test_rw_priority();
    test_idle_sram_ready();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
